// File: rtl/rs_frame_sync_if.sv
// Symbol-in / aligned-packet-out bundle between the deinterleaver, the frame sync and the RS decoder.
// master drives the byte stream and observes the aligned packet side; slave is the frame sync.
interface rs_frame_sync_if #(
    parameter int DW      = 8,
    parameter int PKT_LEN = 204
);
    localparam int IW = $clog2(PKT_LEN);

    logic          sym_vld;
    logic [DW-1:0] sym_din;
    logic          pkt_vld;
    logic [DW-1:0] pkt_dout;
    logic          pkt_sop;
    logic          pkt_eop;
    logic          pkt_inv;
    logic [IW-1:0] byte_idx;
    logic          locked;

    modport master (
        output sym_vld, sym_din,
        input  pkt_vld, pkt_dout, pkt_sop, pkt_eop, pkt_inv, byte_idx, locked
    );

    modport slave (
        input  sym_vld, sym_din,
        output pkt_vld, pkt_dout, pkt_sop, pkt_eop, pkt_inv, byte_idx, locked
    );
endinterface

// File: rtl/rs_frame_sync.sv
// Purpose: finds the RS packet boundary from periodic sync bytes (HUNT/VERIFY/LOCK) and emits aligned packets.
// Latency: 1 clk from accepted byte to pkt_dout/pkt_vld.
// Backpressure: none; one byte per clk is always accepted, gaps in sym_vld simply freeze the block.
module rs_frame_sync #(
    parameter int unsigned    DW         = 8,
    parameter int unsigned    PKT_LEN    = 204,
    parameter logic [DW-1:0]  SYNC       = 8'h47,
    parameter logic [DW-1:0]  SYNC_INV   = 8'hB8,
    parameter int unsigned    LOCK_CNT   = 3,
    parameter int unsigned    UNLOCK_CNT = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    rs_frame_sync_if.slave     sif
);
    localparam int IW = $clog2(PKT_LEN);
    localparam int HW = $clog2(LOCK_CNT + 1);
    localparam int MW = $clog2(UNLOCK_CNT + 1);

    localparam logic [IW-1:0] POS_LAST = IW'(PKT_LEN - 1);
    localparam logic [HW-1:0] HIT_MAX  = HW'(LOCK_CNT);
    localparam logic [MW-1:0] MISS_MAX = MW'(UNLOCK_CNT);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCK   = 2'd2
    } state_t;

    state_t        state;
    logic [IW-1:0] pos;
    logic [HW-1:0] hit_cnt;
    logic [MW-1:0] miss_cnt;

    logic          pkt_vld_q;
    logic [DW-1:0] pkt_dout_q;
    logic          pkt_sop_q;
    logic          pkt_eop_q;
    logic          pkt_inv_q;
    logic [IW-1:0] byte_idx_q;
    logic          locked_q;

    logic          is_hit;
    logic          at_sync;
    logic [IW-1:0] pos_nxt;
    logic [HW-1:0] hit_inc;
    logic [MW-1:0] miss_inc;
    logic          gain_lock;
    logic          lose_lock;
    logic          emit;

    always_comb begin
        is_hit    = (sif.sym_din == SYNC) || (sif.sym_din == SYNC_INV);
        at_sync   = (pos == '0);
        pos_nxt   = (pos == POS_LAST) ? '0 : pos + 1'b1;
        // Saturating increments keep the counters bounded by their thresholds.
        hit_inc   = (hit_cnt  == HIT_MAX)  ? hit_cnt  : hit_cnt  + 1'b1;
        miss_inc  = (miss_cnt == MISS_MAX) ? miss_cnt : miss_cnt + 1'b1;
        gain_lock = sif.sym_vld && (state == VERIFY) && at_sync && is_hit && (hit_inc == HIT_MAX);
        lose_lock = sif.sym_vld && (state == LOCK) && at_sync && !is_hit && (miss_inc == MISS_MAX);
        // The sync that confirms lock is emitted; the miss that drops lock is not.
        emit      = gain_lock || (sif.sym_vld && (state == LOCK) && !lose_lock);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= HUNT;
            pos        <= '0;
            hit_cnt    <= '0;
            miss_cnt   <= '0;
            pkt_vld_q  <= 1'b0;
            pkt_dout_q <= '0;
            pkt_sop_q  <= 1'b0;
            pkt_eop_q  <= 1'b0;
            pkt_inv_q  <= 1'b0;
            byte_idx_q <= '0;
            locked_q   <= 1'b0;
        end else begin
            pkt_vld_q <= 1'b0;
            pkt_sop_q <= 1'b0;
            pkt_eop_q <= 1'b0;
            pkt_inv_q <= 1'b0;

            if (sif.sym_vld) begin
                unique case (state)
                    HUNT: begin
                        if (is_hit) begin
                            state   <= VERIFY;
                            pos     <= IW'(1);
                            hit_cnt <= HW'(1);
                        end
                    end
                    VERIFY: begin
                        pos <= pos_nxt;
                        if (at_sync) begin
                            if (is_hit) begin
                                hit_cnt <= hit_inc;
                                if (gain_lock) begin
                                    state    <= LOCK;
                                    miss_cnt <= '0;
                                    locked_q <= 1'b1;
                                end
                            end else begin
                                // A failed candidate is abandoned; this byte is not retried as a sync.
                                state   <= HUNT;
                                hit_cnt <= '0;
                            end
                        end
                    end
                    LOCK: begin
                        pos <= pos_nxt;
                        if (at_sync) begin
                            if (is_hit) begin
                                miss_cnt <= '0;
                            end else begin
                                miss_cnt <= miss_inc;
                                if (lose_lock) begin
                                    state    <= HUNT;
                                    hit_cnt  <= '0;
                                    locked_q <= 1'b0;
                                end
                            end
                        end
                    end
                    default: begin
                        state <= HUNT;
                    end
                endcase
            end

            if (emit) begin
                pkt_vld_q  <= 1'b1;
                pkt_dout_q <= sif.sym_din;
                byte_idx_q <= pos;
                pkt_sop_q  <= at_sync;
                pkt_eop_q  <= (pos == POS_LAST);
                pkt_inv_q  <= at_sync && (sif.sym_din == SYNC_INV);
            end
        end
    end

    assign sif.pkt_vld  = pkt_vld_q;
    assign sif.pkt_dout = pkt_dout_q;
    assign sif.pkt_sop  = pkt_sop_q;
    assign sif.pkt_eop  = pkt_eop_q;
    assign sif.pkt_inv  = pkt_inv_q;
    assign sif.byte_idx = byte_idx_q;
    assign sif.locked   = locked_q;
endmodule
